// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   localparam int MEM_LAT_MAX = 8;
   localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/rr_sel2.sv
// Two-way round-robin pick between fetch and data requesters.
module rr_sel2
   import mem_arb_pkg::*;
(
   input  logic   i_req_i,
   input  logic   d_req_i,
   input  owner_e last_i,
   output owner_e grant_o,
   output logic   grant_valid_o
);

   always_comb begin
      grant_valid_o = i_req_i | d_req_i;
      grant_o       = OWN_I;
      // On contention the side that did not win last time goes first.
      if (i_req_i && d_req_i)
         grant_o = (last_i == OWN_I) ? OWN_D : OWN_I;
      else if (d_req_i)
         grant_o = OWN_D;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the core's fetch and
// load/store ports; one transaction in flight, fixed read latency.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [AW-1:0] i_addr,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_valid,
   output logic          d_ready,
   input  logic          d_we,
   input  logic [3:0]    d_wmask,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_wmask,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   arb_state_e       state_q, state_d;
   owner_e           owner_q, owner_d;
   owner_e           last_q,  last_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [AW-1:0]    addr_q,  addr_d;
   logic             we_q,    we_d;
   logic [3:0]       wmask_q, wmask_d;
   logic [DW-1:0]    wdata_q, wdata_d;

   owner_e gnt;
   logic   gnt_vld;

   rr_sel2 u_sel (
      .i_req_i       (i_valid),
      .d_req_i       (d_valid),
      .last_i        (last_q),
      .grant_o       (gnt),
      .grant_valid_o (gnt_vld)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wmask_d   = wmask_q;
      wdata_d   = wdata_q;
      i_ready   = 1'b0;
      d_ready   = 1'b0;
      i_rvalid  = 1'b0;
      i_rdata   = '0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_wmask = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            // Nothing is accepted while reset is held, so ready stays low too.
            if (gnt_vld && rst) begin
               owner_d = gnt;
               last_d  = gnt;
               state_d = ACCESS;
               if (gnt == OWN_I) begin
                  i_ready = 1'b1;
                  addr_d  = i_addr;
                  we_d    = 1'b0;
                  wmask_d = '0;
                  wdata_d = '0;
               end else begin
                  d_ready = 1'b1;
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wmask_d = d_wmask;
                  wdata_d = d_wdata;
               end
            end
         end
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_wmask = wmask_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            cnt_d     = CNT_W'(MEM_LAT - 1);
            state_d   = (MEM_LAT == 1) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = RESP;
         end
         RESP: begin
            if (owner_q == OWN_I) begin
               i_rvalid = 1'b1;
               i_rdata  = mem_rdata;
            end else begin
               d_rvalid = 1'b1;
               d_rdata  = we_q ? '0 : mem_rdata;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
         last_q  <= OWN_D;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wmask_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wmask_q <= wmask_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word memory between the RISC-V core's instruction-fetch port and its data load/store port.
- Accepts one request at a time through a valid/ready handshake and drives the memory for one cycle.
- Waits out the fixed memory read latency, then returns a one-cycle response to the requester that was granted.
- Sits between riscv core memory ports and the unified instruction/data memory; replaces the dual-port memory model with a realistic shared port.

Parameters:
- AW, 32, address width (byte address, passed to memory unchanged).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_valid  in  1  instruction-fetch request valid.
- i_ready  out  1  fetch request accepted this cycle.
- i_addr  in  AW  fetch address.
- i_rvalid  out  1  fetch response valid, one cycle.
- i_rdata  out  DW  fetched word.
- d_valid  in  1  data request valid.
- d_ready  out  1  data request accepted this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_wmask  in  4  store byte-enable.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rvalid  out  1  data response valid, one cycle; also acknowledges stores.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_wmask  out  4  memory byte-enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE and last_grant goes to DATA, so fetch wins the first contention.
  - All outputs are 0.
  - Reset mid-transaction aborts the transaction: no response is issued and no further mem_en is driven.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - i_ready and d_ready are combinational; at most one is high, and only for the winner.
  - Winner selection:
    - Only one valid: that requester wins.
    - Both valid: the requester not equal to last_grant wins.
  - On acceptance:
    - Latch addr, we, wmask, wdata and owner.
    - For fetch requests, we=0 and wmask=0.
    - Set last_grant to the owner.
    - Go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS (1 cycle):
  - mem_en=1; mem_we, mem_wmask, mem_addr and mem_wdata come from the latches.
  - Load cnt with MEM_LAT-1.
  - Next state: RESP if MEM_LAT==1, else WAIT.
- WAIT:
  - mem_en=0; decrement cnt.
  - Go to RESP when cnt reaches 1 (decrement to 0).
  - Stay in WAIT for exactly MEM_LAT-1 cycles.
- RESP (cycle ACCESS+MEM_LAT):
  - Owner's rvalid=1 for exactly one cycle.
  - Owner's rdata = mem_rdata for loads and fetches, 0 for stores.
  - The non-owner's rvalid=0 and rdata=0.
  - Next state is IDLE; there is no response backpressure.
- Latency and throughput:
  - Request accept to rvalid is MEM_LAT+1 cycles.
  - Throughput is one transaction per MEM_LAT+2 cycles.
- Requester rules: valid and payload must stay stable until ready.
  - Requests arriving while busy are held off with ready=0.
  - They are not dropped.
- rdata outputs are 0 whenever rvalid=0.
- mem_* outputs are 0 outside ACCESS, which gives deterministic waveforms.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, ACCESS, WAIT, RESP}.
  - typedef enum owner_e {OWN_I, OWN_D}.
  - Constant MEM_LAT_MAX = 8.
- One sub-module, rr_sel2: combinational 2-way round-robin pick from (i_valid, d_valid, last_grant), outputs grant and grant_valid.
- The FSM, counter and latches live in mem_port_arbiter.

Test Plan:
- MEM_LAT=1, single fetch, i_addr=0x0000_0004, memory word 0x0fe26013:
  - i_ready=1 in cycle 0 and mem_en=1 in cycle 1.
  - i_rvalid=1 with i_rdata=0x0fe26013 in cycle 2.
  - d_rvalid stays 0.
- MEM_LAT=3, store d_addr=0x10, d_wdata=0xdeadbeef, d_wmask=4'b1111:
  - mem_we=1 in cycle 1 only.
  - d_rvalid=1 with d_rdata=0 in cycle 4.
  - A following load from 0x10 returns 0xdeadbeef.
- Contention after reset, i_valid=d_valid=1 held:
  - Grant order is I, D, I, D.
  - Each response arrives MEM_LAT+1 cycles after its acceptance.
  - Exactly one ready is high per accepting cycle.
- Request during busy: d_valid rises in the ACCESS cycle of a fetch.
  - d_ready stays 0 until IDLE, then goes to 1.
  - Load data is correct.
- Reset mid-op: MEM_LAT=4, rst=0 during WAIT.
  - Next cycle: busy=0, no i_rvalid or d_rvalid ever issued, mem_en=0.
  - A new fetch after reset completes normally.
- Partial store d_wmask=4'b0010 to a word holding 0x11223344 with d_wdata=0x0000aa00:
  - mem_wmask=4'b0010.
  - A readback returns 0x1122aa44.
